// File: rtl/rv32_pkg.sv
// Shared RV32I constants and types for the front end.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// RV32I fetch: one outstanding imem request, result held until out_ready; 3 cycles/instr at zero wait.
// Redirects win in every state; a wrong-path response still in flight is swallowed via drop_q.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC & ALIGN_MASK;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= RV32_NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_INC;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_instr_d = imem_rsp_data;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides whatever the state logic decided above.
    if (redirect_valid) begin
      pc_d        = redirect_pc & ALIGN_MASK;
      out_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          // An old-PC request accepted this cycle is already gone; mark its reply for discard.
          if (imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            out_pc_d    = out_pc_q;
            out_instr_d = out_instr_q;
            drop_d      = 1'b0;
            state_d     = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_instr      = out_instr_q;

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (state_q == S_WAIT));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !out_ready && !redirect_valid) |=>
      (out_valid_q && $stable(out_pc_q) && $stable(out_instr_q)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, straight-line fetch, stall, redirects and PC wrap.
module tb_if_fetch_unit;

  localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready, out_valid;
  logic [31:0] out_pc, out_instr;

  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_out_valid;
  logic [31:0] w_out_pc, w_out_instr;

  int unsigned mem_delay;
  int          passed;
  int          total;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_ready(1'b1), .out_valid(w_out_valid), .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory models: act on the falling edge, reply mem_delay cycles after acceptance.
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      imem_rsp_valid = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = pend_addr ^ MEM_KEY;
          pend = 1'b0;
        end else begin
          pend_cnt = pend_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = mem_delay;
      end
    end
  end

  logic        w_pend;
  logic [31:0] w_pend_addr;
  always @(negedge clk) begin
    if (rst) begin
      w_pend = 1'b0;
      w_rsp_valid = 1'b0;
    end else begin
      w_rsp_valid = 1'b0;
      if (w_pend) begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = w_pend_addr ^ MEM_KEY;
        w_pend = 1'b0;
      end
      if (w_req_valid) begin
        w_pend      = 1'b1;
        w_pend_addr = w_addr;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    w_rsp_valid    = 1'b0;
    w_rsp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    mem_delay      = 0;

    // Reset held for three edges.
    step(3);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_req_valid", imem_req_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_addr, 32'h0000_0100);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

    // Straight-line fetch: accept on edge 4, present on edge 5.
    step(2);
    check("seq0_valid", out_valid, 1'b1);
    check("seq0_pc", out_pc, 32'h0000_0100);
    check("seq0_instr", out_instr, 32'h5A5A_0100);
    check("wrap0_pc", w_out_pc, 32'hFFFF_FFFC);
    check("wrap0_instr", w_out_instr, 32'hA5A5_FFFC);
    step(1);
    check("seq0_retired", out_valid, 1'b0);
    step(1);
    out_ready = 1'b0;
    step(1);
    check("seq1_valid", out_valid, 1'b1);
    check("seq1_pc", out_pc, 32'h0000_0104);
    check("seq1_instr", out_instr, 32'h5A5A_0104);
    check("wrap1_pc", w_out_pc, 32'h0000_0000);
    check("wrap1_instr", w_out_instr, 32'h5A5A_0000);

    // Stall on 0x104 for five cycles.
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_pc", out_pc, 32'h0000_0104);
      check("stall_instr", out_instr, 32'h5A5A_0104);
      check("stall_no_req", imem_req_valid, 1'b0);
      if (i < 4) step(1);
    end
    out_ready = 1'b1;
    step(1);
    check("unstall_valid", out_valid, 1'b0);
    check("unstall_req", imem_req_valid, 1'b1);
    check("unstall_addr", imem_addr, 32'h0000_0108);
    step(2);
    check("seq2_valid", out_valid, 1'b1);
    check("seq2_pc", out_pc, 32'h0000_0108);
    check("seq2_instr", out_instr, 32'h5A5A_0108);

    // Redirect while waiting on a slow response for 0x10C.
    mem_delay = 2;
    step(2);
    check("rw_in_wait", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rw_discard_valid", out_valid, 1'b0);
      check("rw_wait_no_req", imem_req_valid, 1'b0);
      step(1);
    end
    check("rw_discard_valid", out_valid, 1'b0);
    check("rw_req_valid", imem_req_valid, 1'b1);
    check("rw_req_addr", imem_addr, 32'h0000_0200);
    mem_delay = 0;
    step(2);
    check("rw_out_valid", out_valid, 1'b1);
    check("rw_out_pc", out_pc, 32'h0000_0200);
    check("rw_out_instr", out_instr, 32'h5A5A_0200);

    // Redirect in the same cycle as the response; target bits [1:0] ignored.
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0301;
    step(1);
    redirect_valid = 1'b0;
    check("rc_out_valid", out_valid, 1'b0);
    check("rc_req_valid", imem_req_valid, 1'b1);
    check("rc_req_addr", imem_addr, 32'h0000_0300);
    step(1);
    check("rc_wait_valid", out_valid, 1'b0);
    step(1);
    check("rc_out_valid2", out_valid, 1'b1);
    check("rc_out_pc", out_pc, 32'h0000_0300);
    check("rc_out_instr", out_instr, 32'h5A5A_0300);

    // Redirect while holding, with out_ready also high: held instruction dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step(1);
    redirect_valid = 1'b0;
    check("rh_out_valid", out_valid, 1'b0);
    check("rh_req_addr", imem_addr, 32'h0000_0400);
    step(2);
    check("rh_out_pc", out_pc, 32'h0000_0400);
    check("rh_out_instr", out_instr, 32'h5A5A_0400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
